multicycle_sequencer: RTL and testbench
=======================================

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: i_clk and i_rst_n.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- i_clk  in  1  rising-edge clock
- i_rst_n  in  1  async active-low reset
- i_isLoad  in  1  decoded: instruction is a load
- i_dMemWe  in  1  decoded: instruction is a store
- i_regWe  in  1  decoded: instruction writes the register file
- i_BRop  in  1  decoded: instruction is a branch
- i_branchTaken  in  1  ALU branch condition, valid in EX
- i_iMemReady  in  1  instruction memory has returned data
- i_dMemReady  in  1  data memory has completed the access
- o_iMemReq  out  1  instruction fetch request
- o_irWe  out  1  instruction register load
- o_opLatchWe  out  1  operand A/B latch load
- o_aluLatchWe  out  1  ALU-out latch load
- o_dMemReq  out  1  data memory request
- o_dMemWrite  out  1  data memory write strobe
- o_regWe  out  1  register file write strobe
- o_pcWe  out  1  PC update strobe
- o_pcSrc  out  1  0 = PC+4, 1 = branch target
- o_instrDone  out  1  retire pulse
- o_state  out  3  current state encoding
- o_cycleCnt  out  32  cycle counter
- o_instrCnt  out  32  retired-instruction counter

Function
REQ-003 The FSM SHALL use the states IF=0, ID=1, EX=2, MEM=3 and WB=4; o_state SHALL equal the state register.
REQ-004 Stay in IF while i_iMemReady=0; o_iMemReq=1 throughout IF; o_irWe=1 only in the cycle where IF and i_iMemReady=1, after which the next state SHALL be ID.
REQ-005 ID SHALL last one cycle with o_opLatchWe=1, then go to EX.
REQ-006 EX SHALL last one cycle with o_aluLatchWe=1.
REQ-007 From EX, the next state SHALL be chosen by priority:
- i_BRop: IF, with o_pcWe=1 and o_pcSrc=i_branchTaken
- i_isLoad or i_dMemWe: MEM
- i_regWe: WB
- otherwise: IF, with o_pcWe=1 and o_pcSrc=0
REQ-008 MEM behaviour:
- o_dMemReq=1 throughout; o_dMemWrite=i_dMemWe throughout.
- Hold MEM while i_dMemReady=0.
- On i_dMemReady=1: a load SHALL go to WB; a store SHALL go to IF with o_pcWe=1 and o_pcSrc=0.
REQ-009 WB SHALL last one cycle with o_regWe=1, o_pcWe=1 and o_pcSrc=0, then go to IF.
REQ-010 o_pcWe SHALL assert exactly once per instruction, in the instruction's final cycle; o_instrDone SHALL equal o_pcWe.
REQ-011 o_pcSrc SHALL be 0 in every cycle where o_pcWe=0.
REQ-012 All strobes SHALL be combinational from the state register and inputs; the state SHALL update only on the rising edge of i_clk.
REQ-013 Decoded inputs SHALL be sampled in EX and MEM only; changes in other states SHALL have no effect.
REQ-014 An illegal state encoding (5-7) SHALL transition to IF on the next clock with all strobes 0.
REQ-015 Simultaneous i_iMemReady and i_dMemReady SHALL be acted on only according to the current state.

Reset
REQ-016 While i_rst_n=0, the state SHALL be IF immediately (asynchronously), independent of i_clk.
REQ-017 Reset values: state IF; counters 0; all strobes 0 except o_iMemReq, which follows state IF.
REQ-018 A reset asserted mid-instruction (any state, including a MEM wait) SHALL abandon the instruction: no o_pcWe or o_regWe, and the counters cleared.
REQ-019 The first fetch SHALL begin on the first rising edge after reset is released.

Configuration
REQ-020 The macro MULTICYCLE_SEQUENCER_PERF_EN SHALL compile the performance counters in or out.
- Defined: o_cycleCnt increments every clock out of reset; o_instrCnt increments on each o_instrDone; both wrap 0xFFFFFFFF->0.
- Undefined: both outputs SHALL be constant 0 and no counter flops SHALL exist.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- R-type (regWe=1), ready tied high -> states 0,1,2,4,0; o_regWe in cycle 4; o_instrCnt=1 after 4 cycles (PERF_EN).
- Load with i_dMemReady delayed 3 cycles -> MEM held 4 cycles; o_dMemWrite=0; then WB; total 8 cycles.
- Store, ready tied high -> 0,1,2,3,0; o_dMemWrite=1 in MEM; o_pcWe in MEM; o_regWe never asserted.
- Branch with i_branchTaken=1, then 0 -> o_pcWe with o_pcSrc=1, then o_pcSrc=0, both in EX; 3 cycles each.
- Reset pulled low during MEM wait -> o_state=0 at once; no o_pcWe; counters 0.
- PERF_EN with o_cycleCnt preloaded to 0xFFFFFFFF (force) -> wraps to 0 on the next clock.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multicycle IF/ID/EX/MEM/WB control sequencer: one FSM plus optional perf counters.
// Define MULTICYCLE_SEQUENCER_PERF_EN to build the cycle/retired-instruction counters.
module multicycle_sequencer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_isLoad,
  input  logic        i_dMemWe,
  input  logic        i_regWe,
  input  logic        i_BRop,
  input  logic        i_branchTaken,
  input  logic        i_iMemReady,
  input  logic        i_dMemReady,
  output logic        o_iMemReq,
  output logic        o_irWe,
  output logic        o_opLatchWe,
  output logic        o_aluLatchWe,
  output logic        o_dMemReq,
  output logic        o_dMemWrite,
  output logic        o_regWe,
  output logic        o_pcWe,
  output logic        o_pcSrc,
  output logic        o_instrDone,
  output logic [2:0]  o_state,
  output logic [31:0] o_cycleCnt,
  output logic [31:0] o_instrCnt
);

  typedef enum logic [2:0] {
    stIf  = 3'd0,
    stId  = 3'd1,
    stEx  = 3'd2,
    stMem = 3'd3,
    stWb  = 3'd4
  } stateT;

  stateT stateReg, stateNext;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) stateReg <= stIf;
    else          stateReg <= stateNext;
  end

  always_comb begin
    stateNext    = stIf;
    o_iMemReq    = 1'b0;
    o_irWe       = 1'b0;
    o_opLatchWe  = 1'b0;
    o_aluLatchWe = 1'b0;
    o_dMemReq    = 1'b0;
    o_dMemWrite  = 1'b0;
    o_regWe      = 1'b0;
    o_pcWe       = 1'b0;
    o_pcSrc      = 1'b0;
    case (stateReg)
      stIf: begin
        o_iMemReq = 1'b1;
        // Reset pins the state to IF; keep the IR load quiet while it is held.
        o_irWe    = i_iMemReady & i_rst_n;
        stateNext = i_iMemReady ? stId : stIf;
      end
      stId: begin
        o_opLatchWe = 1'b1;
        stateNext   = stEx;
      end
      stEx: begin
        o_aluLatchWe = 1'b1;
        if (i_BRop) begin
          o_pcWe    = 1'b1;
          o_pcSrc   = i_branchTaken;
          stateNext = stIf;
        end else if (i_isLoad || i_dMemWe) begin
          stateNext = stMem;
        end else if (i_regWe) begin
          stateNext = stWb;
        end else begin
          o_pcWe    = 1'b1;
          stateNext = stIf;
        end
      end
      stMem: begin
        o_dMemReq   = 1'b1;
        o_dMemWrite = i_dMemWe;
        if (!i_dMemReady) begin
          stateNext = stMem;
        end else if (i_isLoad) begin
          stateNext = stWb;
        end else begin
          o_pcWe    = 1'b1;
          stateNext = stIf;
        end
      end
      stWb: begin
        o_regWe   = 1'b1;
        o_pcWe    = 1'b1;
        stateNext = stIf;
      end
      default: stateNext = stIf;
    endcase
  end

  assign o_instrDone = o_pcWe;
  assign o_state     = stateReg;

`ifdef MULTICYCLE_SEQUENCER_PERF_EN
  logic [31:0] cycleCntReg, instrCntReg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycleCntReg <= 32'd0;
      instrCntReg <= 32'd0;
    end else begin
      cycleCntReg <= cycleCntReg + 32'd1;
      if (o_instrDone) instrCntReg <= instrCntReg + 32'd1;
    end
  end

  assign o_cycleCnt = cycleCntReg;
  assign o_instrCnt = instrCntReg;
`else
  assign o_cycleCnt = 32'd0;
  assign o_instrCnt = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: directed scenarios, randomized instructions,
// mid-instruction reset and (with MULTICYCLE_SEQUENCER_PERF_EN) counter wrap.
module tb_multicycle_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_isLoad = 1'b0, i_dMemWe = 1'b0, i_regWe = 1'b0, i_BRop = 1'b0;
  logic        i_branchTaken = 1'b0, i_iMemReady = 1'b0, i_dMemReady = 1'b0;
  logic        o_iMemReq, o_irWe, o_opLatchWe, o_aluLatchWe, o_dMemReq, o_dMemWrite;
  logic        o_regWe, o_pcWe, o_pcSrc, o_instrDone;
  logic [2:0]  o_state;
  logic [31:0] o_cycleCnt, o_instrCnt;

  always #5 i_clk = ~i_clk;

  multicycle_sequencer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_isLoad(i_isLoad), .i_dMemWe(i_dMemWe), .i_regWe(i_regWe), .i_BRop(i_BRop),
    .i_branchTaken(i_branchTaken), .i_iMemReady(i_iMemReady), .i_dMemReady(i_dMemReady),
    .o_iMemReq(o_iMemReq), .o_irWe(o_irWe), .o_opLatchWe(o_opLatchWe),
    .o_aluLatchWe(o_aluLatchWe), .o_dMemReq(o_dMemReq), .o_dMemWrite(o_dMemWrite),
    .o_regWe(o_regWe), .o_pcWe(o_pcWe), .o_pcSrc(o_pcSrc), .o_instrDone(o_instrDone),
    .o_state(o_state), .o_cycleCnt(o_cycleCnt), .o_instrCnt(o_instrCnt)
  );

  // Strobe order: iMemReq irWe opLatchWe aluLatchWe dMemReq dMemWrite regWe pcWe pcSrc instrDone
  wire [9:0] obsStrobes = {o_iMemReq, o_irWe, o_opLatchWe, o_aluLatchWe, o_dMemReq,
                           o_dMemWrite, o_regWe, o_pcWe, o_pcSrc, o_instrDone};

`ifdef MULTICYCLE_SEQUENCER_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  localparam int KRtype = 0, KLoad = 1, KStore = 2, KBranch = 3, KNop = 4;

  int checks = 0;
  int errors = 0;
  logic [31:0] expCycles = 32'd0;
  logic [31:0] expInstr  = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkCounters(input string tag);
    check({tag, "/cycleCnt"}, o_cycleCnt, PerfEn ? expCycles : 32'd0);
    check({tag, "/instrCnt"}, o_instrCnt, PerfEn ? expInstr : 32'd0);
  endtask

  // Drive the decoded fields an instruction of this kind presents in EX/MEM.
  task automatic driveDecode(input int kind, input bit taken);
    i_BRop        = (kind == KBranch);
    i_isLoad      = (kind == KLoad);
    i_dMemWe      = (kind == KStore);
    i_regWe       = (kind == KRtype) || (kind == KLoad) ||
                    ((kind == KStore || kind == KBranch) && 1'($urandom));
    i_branchTaken = (kind == KBranch) ? taken : 1'($urandom);
    if (kind == KBranch) begin
      i_isLoad = 1'($urandom);
      i_dMemWe = 1'($urandom);
    end
  endtask

  // Reference: an instruction is a list of per-cycle states derived from its kind and
  // memory latencies; the final cycle of the list is where it retires.
  task automatic runInstr(input string name, input int kind, input int iLat, input int dLat,
                          input bit taken, input int maxSteps);
    int st[$];
    for (int j = 0; j <= iLat; j++) st.push_back(0);
    st.push_back(1);
    st.push_back(2);
    if (kind == KLoad || kind == KStore) for (int j = 0; j <= dLat; j++) st.push_back(3);
    if (kind == KRtype || kind == KLoad) st.push_back(4);
    for (int k = 0; k < st.size() && k < maxSteps; k++) begin
      int s;
      bit last, lastIn;
      logic [9:0] e;
      s      = st[k];
      last   = (k == st.size() - 1);
      lastIn = last || (st[k+1] != s);
      i_iMemReady = (s == 0) ? lastIn : 1'($urandom);
      i_dMemReady = (s == 3) ? lastIn : 1'($urandom);
      if (s == 2 || s == 3) driveDecode(kind, taken);
      else begin
        i_BRop = 1'($urandom); i_isLoad = 1'($urandom); i_dMemWe = 1'($urandom);
        i_regWe = 1'($urandom); i_branchTaken = 1'($urandom);
      end
      e = {s == 0, s == 0 && lastIn, s == 1, s == 2, s == 3, s == 3 && kind == KStore,
           s == 4, last, last && kind == KBranch && taken, last};
      #1;
      check($sformatf("%s/step%0d/state", name, k), {29'd0, o_state}, s);
      check($sformatf("%s/step%0d/strobes", name, k), {22'd0, obsStrobes}, {22'd0, e});
      checkCounters($sformatf("%s/step%0d", name, k));
      @(negedge i_clk);
      expCycles = expCycles + 32'd1;
      if (last) expInstr = expInstr + 32'd1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with instruction memory ready: only the fetch request may show.
    i_iMemReady = 1'b1;
    #1;
    check("reset/state", {29'd0, o_state}, 32'd0);
    check("reset/strobes", {22'd0, obsStrobes}, {22'd0, 10'b10_0000_0000});
    checkCounters("reset");
    @(posedge i_clk); #1;
    check("resetEdge/state", {29'd0, o_state}, 32'd0);
    check("resetEdge/strobes", {22'd0, obsStrobes}, {22'd0, 10'b10_0000_0000});
    @(negedge i_clk);
    i_rst_n = 1'b1;

    runInstr("rtype",    KRtype,  0, 0, 1'b0, 99);
    runInstr("loadSlow", KLoad,   0, 3, 1'b0, 99);
    runInstr("store",    KStore,  0, 0, 1'b0, 99);
    runInstr("brTaken",  KBranch, 0, 0, 1'b1, 99);
    runInstr("brNot",    KBranch, 0, 0, 1'b0, 99);
    runInstr("nop",      KNop,    2, 0, 1'b0, 99);

    for (int n = 0; n < 40; n++)
      runInstr($sformatf("rand%0d", n), $urandom_range(4, 0), $urandom_range(3, 0),
               $urandom_range(4, 0), 1'($urandom), 99);

    // Reset in the middle of a long MEM wait.
    runInstr("abortLoad", KLoad, 0, 10, 1'b0, 6);
    i_dMemReady = 1'b0;
    i_iMemReady = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    check("midReset/state", {29'd0, o_state}, 32'd0);
    check("midReset/strobes", {22'd0, obsStrobes}, {22'd0, 10'b10_0000_0000});
    expCycles = 32'd0;
    expInstr  = 32'd0;
    checkCounters("midReset");
    @(posedge i_clk); #1;
    check("midResetEdge/state", {29'd0, o_state}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int n = 0; n < 6; n++)
      runInstr($sformatf("post%0d", n), $urandom_range(4, 0), $urandom_range(2, 0),
               $urandom_range(2, 0), 1'($urandom), 99);

`ifdef MULTICYCLE_SEQUENCER_PERF_EN
    i_iMemReady = 1'b0;
    force dut.cycleCntReg = 32'hFFFF_FFFF;
    #1;
    release dut.cycleCntReg;
    check("wrap/preload", o_cycleCnt, 32'hFFFF_FFFF);
    @(negedge i_clk); #1;
    expCycles = 32'd0;
    checkCounters("wrap");
    @(negedge i_clk);
    expCycles = 32'd1;
    runInstr("afterWrap", KRtype, 0, 0, 1'b0, 99);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
